// File: rtl/demux8_capture_pkg.sv
// Shared types and sizing for the serial-to-parallel frame capture block.
package demux8_capture_pkg;

  localparam int unsigned SEL_W_DEF = 3;
  localparam int unsigned N_DEF     = 1 << SEL_W_DEF;

  // Filled-flag pattern that marks a complete frame at the default width.
  localparam logic [N_DEF-1:0] ALL_FILLED = {N_DEF{1'b1}};

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/demux8_capture_slot_decoder.sv
// One-hot slot write-enable decoder; the mirror of the mux select logic.
module demux_slot_decoder #(
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic                   en,
  output logic [(1<<SEL_W)-1:0]  we_c
);

  localparam int unsigned N = 1 << SEL_W;

  // Exactly one enable bit set when en, none otherwise.
  always_comb begin
    we_c = '0;
    if (en) begin
      we_c = N'(1) << sel;
    end
  end

endmodule

// File: rtl/demux8_capture.sv
// Steers serial bits into addressed frame slots and hands the full frame
// out over a valid/ready port.
module demux8_capture
  import demux8_capture_pkg::*;
#(
  parameter int unsigned SEL_W    = SEL_W_DEF,
  parameter bit          AUTO_SEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      s,
  input  logic                  din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(1<<SEL_W)-1:0] out_data,
  output logic [(1<<SEL_W)-1:0] filled,
  output logic                  dup_err
);

  localparam int unsigned N = 1 << SEL_W;
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  state_e           state_q, state_d;
  logic [N-1:0]     data_q, data_d;
  logic [N-1:0]     filled_q, filled_d;
  logic             dup_q, dup_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic             accept_c;
  logic [SEL_W-1:0] sel_c;
  logic [N-1:0]     we_c;

  assign accept_c = in_valid & in_ready_q;
  assign sel_c    = AUTO_SEL ? cnt_q : s;

  demux_slot_decoder #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel  (sel_c),
    .en   (accept_c),
    .we_c (we_c)
  );

  // Next-state: collect bits until every slot is flagged, then hold for the sink.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    filled_d    = filled_q;
    dup_d       = dup_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;

    unique case (state_q)
      COLLECT: begin
        if (accept_c) begin
          data_d   = (data_q & ~we_c) | ({N{din}} & we_c);
          filled_d = filled_q | we_c;
          if ((filled_q & we_c) != '0) begin
            dup_d = 1'b1;
          end
          if (AUTO_SEL) begin
            cnt_d = SEL_W'(cnt_q + SEL_W'(1));
          end
          if (filled_d == ALL_ONES) begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = COLLECT;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          filled_d    = '0;
          dup_d       = 1'b0;
          data_d      = '0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial or pending frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      data_q      <= '0;
      filled_q    <= '0;
      dup_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      filled_q    <= filled_d;
      dup_q       <= dup_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign filled    = filled_q;
  assign dup_err   = dup_q;

endmodule

// File: doc/demux8_capture.md
Name: demux8_capture

Overview:
- Receive-side counterpart of the 8-to-1 mux: takes one serial bit per transfer together with a 3-bit slot select, and steers the bit into the addressed position of an 8-bit frame register.
- When all 8 slots have been written, presents the assembled byte on a valid/ready output port.
- Sits downstream of the mux datapath to rebuild a parallel word from a mux-scanned bit stream.
- Its loopback with the mux is the standard self-check.

Parameters:
- SEL_W, 3, select width; slot count N = 2**SEL_W (default 8).
- AUTO_SEL, 0: when 1, ignore s and use an internal slot counter (0,1,...,N-1, wrap).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  source presents a bit
- in_ready  out  1  block accepts a bit this cycle
- s  in  SEL_W  destination slot (unused when AUTO_SEL=1)
- din  in  1  serial data bit
- out_valid  out  1  assembled frame available
- out_ready  in  1  sink accepts the frame
- out_data  out  N  assembled frame, bit k = bit written to slot k
- filled  out  N  per-slot written flags, for debug and verification
- dup_err  out  1  a slot was written twice within the current frame

Behaviour:
- Reset: one clock and one reset, synchronous and active-low (clk, rst_n). With rst_n=0 at a clk edge, the following all clear to 0:
  - state → COLLECT
  - data register, filled, out_valid, dup_err
  - internal slot counter
- Reset overrides all activity. A partially collected frame or a pending output is discarded. in_ready is 1 in the first cycle after reset is released.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept = in_valid & in_ready. Selected slot is sel = AUTO_SEL ? cnt : s.
- On accept, next edge:
  - data[sel] ← din
  - filled[sel] ← 1
  - if AUTO_SEL: cnt ← cnt+1, wrapping N-1→0
- Duplicate write (filled[sel] already 1 on accept):
  - data is overwritten with the new bit
  - dup_err ← 1, and stays set until the frame is delivered
- Completion:
  - If an accept makes filled all-ones (counting the slot written this cycle), the state goes to HOLD at the same edge.
  - out_valid is asserted the cycle after the final bit's accept (1-cycle latency).
  - out_data = data register, stable throughout HOLD.
- HOLD and out_valid & out_ready:
  - next edge: state → COLLECT; out_valid, filled and dup_err → 0; data → 0
  - dup_err is visible alongside out_valid for the frame it applies to
- out_valid stays high until the handshake completes, i.e. no drop while out_ready=0.
- No bypass: a bit presented during HOLD is not accepted, because in_ready=0, and the source must hold it. This gives a minimum 1-cycle bubble between frames.
- in_valid with in_ready=0 has no effect.
- Slots may be written in any order. Only the all-ones filled vector triggers completion.
- Width rules:
  - s is exactly SEL_W bits, so every value is a legal slot.
  - out_data is N bits with no sign or extension.

Decomposition:
- Shared package:
  - state enum {COLLECT, HOLD}
  - SEL_W default
  - localparam N = 1<<SEL_W
  - localparam ALL_FILLED = {N{1'b1}}
- One natural sub-module: demux_slot_decoder (SEL_W → N one-hot write-enable, gated by accept). The mirror of the mux select logic; reusable and unit-testable on its own.
- Remainder (frame register, flag register, FSM, counter) stays in demux8_capture.

Test Plan:
- In-order fill:
  - Stimulus: after reset, accept s=0..7 on consecutive cycles with din = bits of 8'hE9 (8-bit truncation of the decimal 1001 frame), out_ready=1.
  - Required: out_valid=1 exactly one cycle after the s=7 accept, out_data=8'hE9, dup_err=0; next cycle out_valid=0, filled=0, in_ready=1.
- Out-of-order with backpressure:
  - Stimulus: s order 7,3,0,5,1,6,2,4 writing 8'hA5, out_ready=0 for 5 cycles.
  - Required: out_valid stays 1 with out_data=8'hA5; in_ready=0 and in_valid pulses are ignored; delivery occurs on the first out_ready=1 cycle.
- Duplicate slot:
  - Stimulus: s=2 with din=1, then s=2 with din=0, then the remaining slots with 1s.
  - Required: dup_err=1 from the cycle after the second write; out_data=8'hFB; dup_err clears after the handshake.
- Reset mid-frame:
  - Stimulus: write 5 slots, assert rst_n=0 for one clk edge, then write a full 8'h3C.
  - Required: filled=0 after the reset edge; the frame delivered is 8'h3C with no residue from before the reset.
- AUTO_SEL=1 loopback:
  - Stimulus: drive din from the 8-to-1 mux output with d=8'hE9 and the mux select stepped 0..7, s tied to 0, two frames back-to-back.
  - Required: out_data=8'hE9 both times; cnt wraps 7→0; one bubble cycle between frames.
- Reset in HOLD:
  - Stimulus: assert rst_n=0 while out_valid=1 and out_ready=0.
  - Required: out_valid=0, state COLLECT, and in_ready=1 in the cycle after rst_n returns to 1.
